// File: rtl/dmem_port_arbiter.sv
// Purpose: shares one data-memory port between the MEM stage (D) and fetch/debug reads (F), with D priority and a starvation guard for F.
// Latency: grant is combinational; read data returns registered one cycle after the grant.
// Backpressure: the losing requester holds its request; a granted misaligned D access gets d_err and no memory access.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_f3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_err,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_f3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        D_RD = 2'd1,
        F_RD = 2'd2
    } rsel_t;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [2:0]        f3;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    rsel_t    rsel;
    rsel_t    rsel_nxt;
    mem_cmd_t cmd;
    logic [3:0] wait_cnt;
    logic f_win;
    logic d_win;
    logic misalign;
    logic d_load;

    // Store encodings SH/SW share funct3 with LH/LW, so one check covers both directions.
    assign misalign = d_req & ((((d_f3 == F3_LH) || (d_f3 == F3_LHU)) && d_addr[0]) ||
                               ((d_f3 == F3_LW) && (d_addr[1:0] != 2'b00)));

    assign f_win   = rst & f_req & (~d_req | (wait_cnt == WAIT_MAX));
    assign d_win   = rst & d_req & ~f_win;
    assign d_load  = d_win & ~misalign & ~d_we;

    assign d_gnt   = d_win;
    assign d_err   = d_win & misalign;
    assign f_gnt   = f_win;
    assign f_stall = f_req & ~f_win;

    always_comb begin
        cmd = '0;
        if (f_win) begin
            cmd.rd   = 1'b1;
            cmd.f3   = F3_LW;
            cmd.addr = {f_addr[ADDR_W-1:2], 2'b00};
        end else if (d_win && !misalign) begin
            cmd.rd   = ~d_we;
            cmd.wr   = d_we;
            cmd.f3   = d_f3;
            cmd.addr = d_addr;
            if (d_we) begin
                cmd.wdata = d_wdata;
            end
        end
    end

    assign mem_read  = cmd.rd;
    assign mem_write = cmd.wr;
    assign mem_f3    = cmd.f3;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;

    always_comb begin
        rsel_nxt = IDLE;
        if (d_load) begin
            rsel_nxt = D_RD;
        end else if (f_win) begin
            rsel_nxt = F_RD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsel     <= IDLE;
            wait_cnt <= 4'd0;
            d_rdata  <= '0;
            f_rdata  <= '0;
        end else begin
            rsel <= rsel_nxt;
            if (rsel_nxt == D_RD) begin
                d_rdata <= mem_rdata;
            end
            if (rsel_nxt == F_RD) begin
                f_rdata <= mem_rdata;
            end
            if (!f_req || f_win) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    assign d_rvalid = (rsel == D_RD);
    assign f_rvalid = (rsel == F_RD);

endmodule
